// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB one instruction at a time and drives
// every datapath enable and mux select from the state and the current IR fields.
// Ports:
//   Clock, Reset                 rising-edge clock, async active-high reset
//   Opcode, Funct                IR[31:26], IR[5:0]
//   Zero                         ALU zero flag (used in EXEC for beq)
//   MemReady                     data-memory completion handshake (sampled in MEM)
//   PCWrite, PCSrc, IRWrite      fetch-stage controls
//   RegWrite, RegDst, WDSel      register-file write controls
//   ALUOp, ALUSrc, ExtOp         ALU controls
//   MemRead, MemWrite            data-memory requests
//   MemFault                     sticky MEM-timeout flag
//   State                        current FSM state
//   RetireCnt                    retired-instruction count (only with MC_CTRL_RETIRE_CNT_EN)
// Optional feature macro: MC_CTRL_RETIRE_CNT_EN
module mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic [2:0]  ALUOp,
  output logic        ALUSrc,
  output logic        ExtOp,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemFault,
  output logic [2:0]  State
`ifdef MC_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] RetireCnt
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  localparam logic [1:0] PC_SEQ = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2, PC_REG = 2'd3;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC = 2'd2;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_LUI = 3'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_fault;
  logic             mem_timeout;

  logic       pc_write, ir_write, reg_write, alu_src, ext_op, mem_read, mem_write;
  logic [1:0] pc_src, reg_dst, wd_sel;
  logic [2:0] alu_op;

  // Instruction decode from the held IR fields
  logic is_addu, is_subu, is_jr, is_j, is_jal, is_beq, is_ori, is_lui, is_lw, is_sw;
  logic is_rtype, is_mem, goes_exec;

  assign is_addu   = (Opcode == OP_SPECIAL) && (Funct == FN_ADDU);
  assign is_subu   = (Opcode == OP_SPECIAL) && (Funct == FN_SUBU);
  assign is_jr     = (Opcode == OP_SPECIAL) && (Funct == FN_JR);
  assign is_j      = (Opcode == OP_J);
  assign is_jal    = (Opcode == OP_JAL);
  assign is_beq    = (Opcode == OP_BEQ);
  assign is_ori    = (Opcode == OP_ORI);
  assign is_lui    = (Opcode == OP_LUI);
  assign is_lw     = (Opcode == OP_LW);
  assign is_sw     = (Opcode == OP_SW);
  assign is_rtype  = is_addu || is_subu;
  assign is_mem    = is_lw || is_sw;
  assign goes_exec = is_rtype || is_ori || is_lui || is_mem || is_beq;

  // MemReady in the same cycle overrides the timeout
  assign mem_timeout = (state == S_MEM) && !MemReady && (wait_cnt == CNT_LAST);

  // State, wait counter and sticky fault
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_MEM) && !MemReady && !mem_timeout) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (mem_timeout) begin
        mem_fault <= 1'b1;
      end
    end
  end

  // Next state and per-state controls
  always_comb begin
    state_nxt = state;
    pc_write  = 1'b0;
    pc_src    = PC_SEQ;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    reg_dst   = DST_RT;
    wd_sel    = WD_ALU;
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    ext_op    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        pc_src    = PC_SEQ;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        state_nxt = goes_exec ? S_EXEC : S_FETCH;
        if (is_j) begin
          pc_write = 1'b1;
          pc_src   = PC_JMP;
        end else if (is_jr) begin
          pc_write = 1'b1;
          pc_src   = PC_REG;
        end else if (is_jal) begin
          pc_write  = 1'b1;
          pc_src    = PC_JMP;
          reg_write = 1'b1;
          reg_dst   = DST_RA;
          wd_sel    = WD_PC;
        end
      end
      S_EXEC: begin
        state_nxt = S_WB;
        if (is_rtype) begin
          alu_op = is_subu ? ALU_SUB : ALU_ADD;
        end else if (is_ori) begin
          alu_op  = ALU_OR;
          alu_src = 1'b1;
        end else if (is_lui) begin
          alu_op  = ALU_LUI;
          alu_src = 1'b1;
        end else if (is_mem) begin
          alu_src   = 1'b1;
          ext_op    = 1'b1;
          state_nxt = S_MEM;
        end else if (is_beq) begin
          alu_op    = ALU_SUB;
          pc_write  = Zero;
          pc_src    = PC_BR;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        mem_read  = is_lw;
        mem_write = is_sw;
        if (MemReady) begin
          state_nxt = is_lw ? S_WB : S_FETCH;
        end else if (mem_timeout) begin
          state_nxt = S_FETCH;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = is_rtype ? DST_RD : DST_RT;
        wd_sel    = is_lw ? WD_MEM : WD_ALU;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Enables drop asynchronously while Reset is held
  assign PCWrite  = Reset ? 1'b0 : pc_write;
  assign PCSrc    = Reset ? 2'd0 : pc_src;
  assign IRWrite  = Reset ? 1'b0 : ir_write;
  assign RegWrite = Reset ? 1'b0 : reg_write;
  assign RegDst   = Reset ? 2'd0 : reg_dst;
  assign WDSel    = Reset ? 2'd0 : wd_sel;
  assign ALUOp    = Reset ? 3'd0 : alu_op;
  assign ALUSrc   = Reset ? 1'b0 : alu_src;
  assign ExtOp    = Reset ? 1'b0 : ext_op;
  assign MemRead  = Reset ? 1'b0 : mem_read;
  assign MemWrite = Reset ? 1'b0 : mem_write;
  assign MemFault = mem_fault;
  assign State    = state;

`ifdef MC_CTRL_RETIRE_CNT_EN
  // An instruction retires on the cycle that hands control back to FETCH
  logic        retire;
  logic [31:0] retire_cnt;

  assign retire = (state != S_FETCH) && (state_nxt == S_FETCH);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign RetireCnt = retire_cnt;
`endif

endmodule
